// File: rtl/lsu_subword.sv
// Load/store unit that adapts a word-only data memory to MIPS byte, halfword
// and word accesses. Loads and word stores finish in the request cycle;
// byte/halfword stores read the word, merge the new lane, and write it back
// one cycle later while the CPU is stalled. Byte order is big-endian.
module lsu_subword #(
    parameter int unsigned ADDR_LIMIT = 1024
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    input  logic [31:0] Addr,
    input  logic [31:0] StoreData,
    output logic [31:0] LoadData,
    output logic        Stall,
    output logic        AccErr,
    output logic        ErrSticky,
    output logic        DmemRead,
    output logic        DmemWrite,
    output logic [31:0] DmemAddr,
    output logic [31:0] DmemDataIn,
    input  logic [31:0] DmemDataOut
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_WRITE = 1'b1;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // FSM state and the registered half of the read-modify-write
    logic [0:0]  state_q, state_d;
    logic [31:0] merge_q, merge_d;
    logic [31:2] addr_q, addr_d;
    logic        err_sticky_q, err_sticky_d;

    logic        in_idle;
    logic        req;
    logic        bad_size;
    logic        misaligned;
    logic        out_of_range;
    logic        conflict;
    logic        acc_err;
    logic        load_ok;
    logic        word_store_ok;
    logic        sub_store_ok;

    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] store_lanes;
    logic [3:0]  lane_sel;
    logic [31:0] merged_word;

    assign in_idle = (state_q == ST_IDLE);
    assign req     = MemRead | MemWrite;

    // Request legality; in WRITE the request inputs belong to the store
    // already in flight and are not re-judged.
    assign bad_size     = (Size == 2'b11);
    assign misaligned   = ((Size == SZ_HALF) && Addr[0]) ||
                          ((Size == SZ_WORD) && (Addr[1:0] != 2'b00));
    assign out_of_range = (Addr >= ADDR_LIMIT);
    assign conflict     = MemRead & MemWrite;
    assign acc_err      = in_idle & req & (bad_size | misaligned | out_of_range | conflict);

    assign load_ok       = in_idle & MemRead  & ~acc_err;
    assign word_store_ok = in_idle & MemWrite & ~acc_err & (Size == SZ_WORD);
    assign sub_store_ok  = in_idle & MemWrite & ~acc_err & ((Size == SZ_BYTE) || (Size == SZ_HALF));

    // Replicate the store value across every lane it could occupy so each
    // lane only has to decide "new or old".
    assign store_lanes = (Size == SZ_BYTE) ? {4{StoreData[7:0]}} : {2{StoreData[15:0]}};

    // Per-lane merge: lane gi is big-endian byte offset gi, bits [31-8*gi -: 8]
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_sel[gi] = (Size == SZ_BYTE) ? (Addr[1:0] == 2'(gi))
                                                    : (Addr[1] == ((gi >= 2) ? 1'b1 : 1'b0));
            assign merged_word[31-8*gi -: 8] = lane_sel[gi] ? store_lanes[31-8*gi -: 8]
                                                            : DmemDataOut[31-8*gi -: 8];
        end
    endgenerate

    // Pick the addressed byte out of the big-endian word
    always_comb begin
        load_byte = DmemDataOut[31:24];
        case (Addr[1:0])
            2'd0:    load_byte = DmemDataOut[31:24];
            2'd1:    load_byte = DmemDataOut[23:16];
            2'd2:    load_byte = DmemDataOut[15:8];
            default: load_byte = DmemDataOut[7:0];
        endcase
    end

    assign load_half = Addr[1] ? DmemDataOut[15:0] : DmemDataOut[31:16];

    // Extend the selected lane; anything that is not a legal load returns 0
    always_comb begin
        LoadData = 32'd0;
        if (load_ok) begin
            case (Size)
                SZ_BYTE: LoadData = Unsigned ? {24'd0, load_byte}
                                             : {{24{load_byte[7]}}, load_byte};
                SZ_HALF: LoadData = Unsigned ? {16'd0, load_half}
                                             : {{16{load_half[15]}}, load_half};
                default: LoadData = DmemDataOut;
            endcase
        end
    end

    // Memory-side controls; holding reset suppresses writes and stalls so a
    // store caught mid-flight is dropped cleanly.
    always_comb begin
        DmemRead   = load_ok | sub_store_ok;
        DmemWrite  = Resetn & ((state_q == ST_WRITE) | word_store_ok);
        Stall      = Resetn & sub_store_ok;
        DmemAddr   = {Addr[31:2], 2'b00};
        DmemDataIn = 32'd0;
        if (state_q == ST_WRITE) begin
            DmemRead   = 1'b0;
            DmemAddr   = {addr_q, 2'b00};
            DmemDataIn = merge_q;
        end else if (word_store_ok) begin
            DmemDataIn = StoreData;
        end
    end

    assign AccErr    = acc_err;
    assign ErrSticky = err_sticky_q;

    // Next-state: a legal sub-word store captures the merged word and its
    // address, then WRITE always returns to IDLE after one cycle.
    always_comb begin
        state_d      = state_q;
        merge_d      = merge_q;
        addr_d       = addr_q;
        err_sticky_d = err_sticky_q | acc_err;
        if (state_q == ST_WRITE) begin
            state_d = ST_IDLE;
        end else if (sub_store_ok) begin
            state_d = ST_WRITE;
            merge_d = merged_word;
            addr_d  = Addr[31:2];
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q      <= ST_IDLE;
            merge_q      <= 32'd0;
            addr_q       <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            merge_q      <= merge_d;
            addr_q       <= addr_d;
            err_sticky_q <= err_sticky_d;
        end
    end

endmodule

// File: tb/tb_lsu_subword.sv
// Self-checking bench for lsu_subword: a behavioural word memory, a table of
// directed loads, hand-written multi-cycle store/reset sequences, and a
// randomized run checked against an arithmetic reference model.
module tb_lsu_subword;

    localparam int unsigned LIMIT = 1024;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [1:0]  Size = 2'b00;
    logic        Unsigned = 1'b0;
    logic [31:0] Addr = 32'd0;
    logic [31:0] StoreData = 32'd0;
    logic [31:0] LoadData;
    logic        Stall;
    logic        AccErr;
    logic        ErrSticky;
    logic        DmemRead;
    logic        DmemWrite;
    logic [31:0] DmemAddr;
    logic [31:0] DmemDataIn;
    logic [31:0] DmemDataOut;

    lsu_subword #(.ADDR_LIMIT(LIMIT)) dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .Size        (Size),
        .Unsigned    (Unsigned),
        .Addr        (Addr),
        .StoreData   (StoreData),
        .LoadData    (LoadData),
        .Stall       (Stall),
        .AccErr      (AccErr),
        .ErrSticky   (ErrSticky),
        .DmemRead    (DmemRead),
        .DmemWrite   (DmemWrite),
        .DmemAddr    (DmemAddr),
        .DmemDataIn  (DmemDataIn),
        .DmemDataOut (DmemDataOut)
    );

    always #5 Clock = ~Clock;

    // Word memory: combinational read, write commits on negedge
    logic [31:0] mem [0:255];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_idx = 8'd0;
    logic [31:0] pre_data = 32'd0;

    assign DmemDataOut = (DmemAddr < LIMIT) ? mem[DmemAddr[9:2]] : 32'hDEAD_BEEF;

    always @(negedge Clock) begin
        if (pre_we)
            mem[pre_idx] <= pre_data;
        else if (DmemWrite && (DmemAddr < LIMIT))
            mem[DmemAddr[9:2]] <= DmemDataIn;
    end

    logic [31:0] ref_mem [0:255];
    int compared = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge Clock);
        #2;
    endtask

    task automatic set_req(input logic rd, input logic wr, input logic [1:0] sz,
                           input logic uns, input logic [31:0] a, input logic [31:0] d);
        MemRead = rd; MemWrite = wr; Size = sz; Unsigned = uns; Addr = a; StoreData = d;
    endtask

    task automatic preload(input int idx, input logic [31:0] d);
        pre_idx = 8'(idx);
        pre_data = d;
        pre_we = 1'b1;
        @(negedge Clock);
        #1;
        pre_we = 1'b0;
        ref_mem[idx] = d;
    endtask

    // Reference: lane extraction by shifting, sign extension by subtraction
    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                             input logic [1:0] sz, input logic uns);
        int unsigned off, v, width;
        off = a % 4;
        if (sz == 2'b10) return w;
        if (sz == 2'b00) begin
            width = 8;
            v = (w >> (8 * (3 - off))) % 256;
        end else begin
            width = 16;
            v = (w >> (8 * (2 - off))) % 65536;
        end
        if (!uns && v >= (32'd1 << (width - 1))) v = v - (32'd1 << width);
        return v;
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] w, input logic [31:0] a,
                                              input logic [1:0] sz, input logic [31:0] d);
        int unsigned off, sh, mask, val;
        off = a % 4;
        if (sz == 2'b00) begin
            sh = 8 * (3 - off); mask = 32'hFF << sh; val = (d % 256) << sh;
        end else begin
            sh = 8 * (2 - off); mask = 32'hFFFF << sh; val = (d % 65536) << sh;
        end
        return (w & ~mask) | val;
    endfunction

    function automatic logic ref_err(input logic rd, input logic wr, input logic [1:0] sz,
                                     input logic [31:0] a);
        if (!rd && !wr) return 1'b0;
        if (rd && wr) return 1'b1;
        if (sz == 2'b11) return 1'b1;
        if (sz == 2'b01 && (a % 2) != 0) return 1'b1;
        if (sz == 2'b10 && (a % 4) != 0) return 1'b1;
        if (a >= LIMIT) return 1'b1;
        return 1'b0;
    endfunction

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] exp_load;
        logic        exp_err;
        logic        exp_rd;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic        r_rd, r_wr, r_uns, r_err, r_sub, r_word, sticky;
        logic [1:0]  r_sz;
        logic [31:0] r_addr, r_data, exp_ld, exp_word;
        int          sel;

        vecs.push_back('{"lbu_0x11",  1'b1, 1'b0, 2'b00, 1'b1, 32'h11,  32'h0000_0022, 1'b0, 1'b1});
        vecs.push_back('{"lb_0x13",   1'b1, 1'b0, 2'b00, 1'b0, 32'h13,  32'h0000_0044, 1'b0, 1'b1});
        vecs.push_back('{"lw_0x10",   1'b1, 1'b0, 2'b10, 1'b0, 32'h10,  32'h1122_3344, 1'b0, 1'b1});
        vecs.push_back('{"lh_0x20",   1'b1, 1'b0, 2'b01, 1'b0, 32'h20,  32'hFFFF_80FF, 1'b0, 1'b1});
        vecs.push_back('{"lhu_0x20",  1'b1, 1'b0, 2'b01, 1'b1, 32'h20,  32'h0000_80FF, 1'b0, 1'b1});
        vecs.push_back('{"lb_0x21",   1'b1, 1'b0, 2'b00, 1'b0, 32'h21,  32'hFFFF_FFFF, 1'b0, 1'b1});
        vecs.push_back('{"lh_0x12",   1'b1, 1'b0, 2'b01, 1'b0, 32'h12,  32'h0000_3344, 1'b0, 1'b1});
        vecs.push_back('{"lb_0x3ff",  1'b1, 1'b0, 2'b00, 1'b0, 32'h3FF, 32'hFFFF_FF80, 1'b0, 1'b1});
        vecs.push_back('{"lw_mis",    1'b1, 1'b0, 2'b10, 1'b0, 32'h12,  32'h0,         1'b1, 1'b0});
        vecs.push_back('{"lh_mis",    1'b1, 1'b0, 2'b01, 1'b0, 32'h11,  32'h0,         1'b1, 1'b0});
        vecs.push_back('{"size11",    1'b1, 1'b0, 2'b11, 1'b0, 32'h10,  32'h0,         1'b1, 1'b0});
        vecs.push_back('{"rd_and_wr", 1'b1, 1'b1, 2'b10, 1'b0, 32'h10,  32'h0,         1'b1, 1'b0});
        vecs.push_back('{"lw_0x400",  1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0,         1'b1, 1'b0});
        vecs.push_back('{"no_req",    1'b0, 1'b0, 2'b11, 1'b0, 32'h10,  32'h0,         1'b0, 1'b0});

        // Reset behaviour, with a store request pending during reset
        cycle();
        set_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h5555_5555);
        #1;
        check("rst_dmemwrite_word", DmemWrite, 1'b0);
        cycle();
        set_req(1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'h5555_5555);
        #1;
        check("rst_stall_sub", Stall, 1'b0);
        check("rst_dmemwrite_sub", DmemWrite, 1'b0);
        cycle();
        Resetn = 1'b1;
        set_req(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        #1;
        check("rst_errsticky", ErrSticky, 1'b0);
        check("rst_stall", Stall, 1'b0);
        check("rst_dmemwrite", DmemWrite, 1'b0);
        check("rst_loaddata", LoadData, 32'd0);
        check("rst_dmemread", DmemRead, 1'b0);

        for (int w = 0; w < 256; w++) preload(w, $urandom);
        preload(32'h10 >> 2, 32'h1122_3344);
        preload(32'h20 >> 2, 32'h80FF_0000);
        preload(32'h3FC >> 2, 32'h0000_0080);

        // Table-driven single-cycle vectors
        foreach (vecs[i]) begin
            cycle();
            set_req(vecs[i].rd, vecs[i].wr, vecs[i].size, vecs[i].uns, vecs[i].addr, 32'h0);
            #1;
            check({vecs[i].name, "_load"}, LoadData, vecs[i].exp_load);
            check({vecs[i].name, "_err"}, AccErr, vecs[i].exp_err);
            check({vecs[i].name, "_dmemread"}, DmemRead, vecs[i].exp_rd);
            check({vecs[i].name, "_stall"}, Stall, 1'b0);
            $display("vec %s addr=0x%08h load=0x%08h err=%0d", vecs[i].name, vecs[i].addr, LoadData, AccErr);
        end

        // A reset clears the sticky flag raised by the error vectors
        cycle();
        Resetn = 1'b0;
        set_req(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        cycle();
        Resetn = 1'b1;
        #1;
        check("sticky_cleared", ErrSticky, 1'b0);

        // sb 0xAB to 0x12: read-merge cycle, then write cycle
        cycle();
        set_req(1'b0, 1'b1, 2'b00, 1'b0, 32'h12, 32'h1234_56AB);
        #1;
        check("sb_c1_stall", Stall, 1'b1);
        check("sb_c1_dmemwrite", DmemWrite, 1'b0);
        check("sb_c1_dmemread", DmemRead, 1'b1);
        check("sb_c1_err", AccErr, 1'b0);
        cycle();
        #1;
        check("sb_c2_dmemwrite", DmemWrite, 1'b1);
        check("sb_c2_datain", DmemDataIn, 32'h1122_AB44);
        check("sb_c2_addr", DmemAddr, 32'h10);
        check("sb_c2_stall", Stall, 1'b0);
        ref_mem[4] = 32'h1122_AB44;
        cycle();
        set_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        #1;
        check("sb_readback", LoadData, 32'h1122_AB44);
        $display("txn sb 0x12 <= 0xAB readback=0x%08h", LoadData);

        // sh to odd address: error, no write, sticky stays set
        cycle();
        set_req(1'b0, 1'b1, 2'b01, 1'b0, 32'h11, 32'h0000_BEEF);
        #1;
        check("sh_odd_err", AccErr, 1'b1);
        check("sh_odd_dmemwrite", DmemWrite, 1'b0);
        check("sh_odd_stall", Stall, 1'b0);
        check("sh_odd_load", LoadData, 32'd0);
        cycle();
        set_req(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        #1;
        check("sticky_set", ErrSticky, 1'b1);
        cycle();
        #1;
        check("sticky_held", ErrSticky, 1'b1);
        $display("txn sh 0x11 err sticky=%0d", ErrSticky);

        // sw at the address limit is rejected; last legal word is written
        cycle();
        set_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h400, 32'h1234_5678);
        #1;
        check("sw_0x400_err", AccErr, 1'b1);
        check("sw_0x400_dmemwrite", DmemWrite, 1'b0);
        cycle();
        set_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h3FC, 32'h1234_5678);
        #1;
        check("sw_0x3fc_err", AccErr, 1'b0);
        check("sw_0x3fc_dmemwrite", DmemWrite, 1'b1);
        check("sw_0x3fc_datain", DmemDataIn, 32'h1234_5678);
        check("sw_0x3fc_stall", Stall, 1'b0);
        ref_mem[255] = 32'h1234_5678;
        cycle();
        set_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0);
        #1;
        check("sw_0x3fc_readback", LoadData, 32'h1234_5678);
        $display("txn sw 0x3fc readback=0x%08h", LoadData);

        // sh 0xCAFE to 0x10 with reset asserted during the write cycle
        cycle();
        set_req(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        preload(4, 32'h1122_3344);
        cycle();
        set_req(1'b0, 1'b1, 2'b01, 1'b0, 32'h10, 32'h0000_CAFE);
        #1;
        check("abort_c1_stall", Stall, 1'b1);
        cycle();
        Resetn = 1'b0;
        #1;
        check("abort_dmemwrite", DmemWrite, 1'b0);
        check("abort_stall", Stall, 1'b0);
        cycle();
        Resetn = 1'b1;
        set_req(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        #1;
        check("abort_idle_dmemwrite", DmemWrite, 1'b0);
        check("abort_sticky", ErrSticky, 1'b0);
        cycle();
        set_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        #1;
        check("abort_word_kept", LoadData, 32'h1122_3344);
        check("abort_load_stall", Stall, 1'b0);
        $display("txn sh 0x10 aborted by reset word=0x%08h", LoadData);

        // Randomized run against the reference model
        sticky = 1'b0;
        for (int i = 0; i < 400; i++) begin
            cycle();
            sel = $urandom_range(0, 9);
            r_rd = (sel <= 3) || (sel == 8);
            r_wr = ((sel >= 4) && (sel <= 7)) || (sel == 8);
            sel = $urandom_range(0, 15);
            r_sz = (sel == 15) ? 2'b11 : 2'(sel % 3);
            r_uns = 1'($urandom_range(0, 1));
            r_addr = ($urandom_range(0, 9) == 0) ? $urandom_range(LIMIT, LIMIT + 80)
                                                 : $urandom_range(0, LIMIT - 1);
            if ($urandom_range(0, 3) != 0)
                r_addr = (r_sz == 2'b10) ? (r_addr / 4) * 4 : (r_sz == 2'b01) ? (r_addr / 2) * 2 : r_addr;
            r_data = $urandom;
            set_req(r_rd, r_wr, r_sz, r_uns, r_addr, r_data);
            #1;
            r_err  = ref_err(r_rd, r_wr, r_sz, r_addr);
            r_sub  = r_wr && !r_err && (r_sz != 2'b10);
            r_word = r_wr && !r_err && (r_sz == 2'b10);
            exp_ld = (r_rd && !r_err) ? ref_load(ref_mem[r_addr[9:2]], r_addr, r_sz, r_uns) : 32'd0;
            check("rnd_sticky", ErrSticky, sticky);
            check("rnd_err", AccErr, r_err);
            check("rnd_load", LoadData, exp_ld);
            check("rnd_stall", Stall, r_sub);
            check("rnd_dmemwrite", DmemWrite, r_word);
            if (r_word) begin
                check("rnd_sw_data", DmemDataIn, r_data);
                ref_mem[r_addr[9:2]] = r_data;
            end
            sticky = sticky | r_err;
            if (r_sub) begin
                exp_word = ref_merge(ref_mem[r_addr[9:2]], r_addr, r_sz, r_data);
                cycle();
                #1;
                check("rnd_wr_dmemwrite", DmemWrite, 1'b1);
                check("rnd_wr_data", DmemDataIn, exp_word);
                check("rnd_wr_stall", Stall, 1'b0);
                ref_mem[r_addr[9:2]] = exp_word;
            end
            $display("txn %0d rd=%0d wr=%0d size=%0d uns=%0d addr=0x%08h data=0x%08h load=0x%08h err=%0d",
                     i, r_rd, r_wr, r_sz, r_uns, r_addr, r_data, LoadData, AccErr);
        end

        cycle();
        set_req(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
